constructor_timing_unit: RTL and testbench

- Timing and command-sequencing companion of the constructor control unit; sits directly downstream of it.
- Consumes CE_compEN, CE_STOPcompEN, RST, RSH_LE and cmd_SH_EN from the control unit.
- Produces the CNT_compEN_OUT / CNT_STOPcompEN_OUT terminal flags that the control unit samples.
- Holds a parallel-loaded command shift register whose head slot drives the constructor datapath.

---
 rtl/constructor_timing_unit.sv | 120 ++++++++++++
 tb/tb_constructor_timing_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/constructor_timing_unit.sv
// Latency counters and parallel-load command shift register downstream of the constructor control unit.
// Optional sticky protocol checker enabled by defining CTU_PROTOCOL_CHECK_EN.
module constructor_timing_unit #(
    parameter int CNT_W     = 3,
    parameter int COMP_LAT  = 5,
    parameter int STOP_LAT  = 3,
    parameter int CMD_DEPTH = 4,
    parameter int CMD_W     = 2
) (
    input  logic                       clk,
    input  logic                       RST_n,
    input  logic                       CLR,
    input  logic                       CE_compEN,
    input  logic                       CE_STOPcompEN,
    input  logic                       RSH_LE,
    input  logic                       cmd_SH_EN,
    input  logic [CMD_DEPTH*CMD_W-1:0] CMD_IN,
    output logic                       CNT_compEN_OUT,
    output logic                       CNT_STOPcompEN_OUT,
    output logic [CMD_W-1:0]           CMD_OUT,
    output logic                       CMD_VALID,
    output logic                       CMD_LAST,
    output logic                       ERR
);

    localparam int OCC_W = $clog2(CMD_DEPTH + 1);
    localparam logic [CNT_W-1:0] C_LAT = CNT_W'(COMP_LAT);
    localparam logic [CNT_W-1:0] S_LAT = CNT_W'(STOP_LAT);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(CMD_DEPTH);

    logic [CNT_W-1:0]           cnt_c_q, cnt_c_d;
    logic [CNT_W-1:0]           cnt_s_q, cnt_s_d;
    logic                       flag_c_q, flag_c_d;
    logic                       flag_s_q, flag_s_d;
    logic [CMD_DEPTH*CMD_W-1:0] cmd_q, cmd_d;
    logic [OCC_W-1:0]           occ_q, occ_d;

    // Counters saturate at their latency; CLR outranks the enable.
    always_comb begin
        cnt_c_d = cnt_c_q;
        cnt_s_d = cnt_s_q;
        if (CLR) begin
            cnt_c_d = '0;
            cnt_s_d = '0;
        end else begin
            if (CE_compEN && (cnt_c_q < C_LAT))
                cnt_c_d = cnt_c_q + CNT_W'(1);
            if (CE_STOPcompEN && (cnt_s_q < S_LAT))
                cnt_s_d = cnt_s_q + CNT_W'(1);
        end
        flag_c_d = (cnt_c_d == C_LAT);
        flag_s_d = (cnt_s_d == S_LAT);
    end

    // Load beats shift; slot 0 sits in the low bits so a shift is a right shift.
    always_comb begin
        cmd_d = cmd_q;
        occ_d = occ_q;
        if (RSH_LE) begin
            cmd_d = CMD_IN;
            occ_d = OCC_FULL;
        end else if (cmd_SH_EN && (occ_q != '0)) begin
            cmd_d = cmd_q >> CMD_W;
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!RST_n) begin
            cnt_c_q  <= '0;
            cnt_s_q  <= '0;
            flag_c_q <= 1'b0;
            flag_s_q <= 1'b0;
            cmd_q    <= '0;
            occ_q    <= '0;
        end else begin
            cnt_c_q  <= cnt_c_d;
            cnt_s_q  <= cnt_s_d;
            flag_c_q <= flag_c_d;
            flag_s_q <= flag_s_d;
            cmd_q    <= cmd_d;
            occ_q    <= occ_d;
        end
    end

    assign CNT_compEN_OUT     = flag_c_q;
    assign CNT_STOPcompEN_OUT = flag_s_q;
    assign CMD_OUT            = cmd_q[CMD_W-1:0];
    assign CMD_VALID          = (occ_q != '0);
    assign CMD_LAST           = (occ_q == OCC_W'(1));

`ifdef CTU_PROTOCOL_CHECK_EN
    logic err_q, err_d;

    // Underflow, overwrite of unissued commands, or counting past saturation.
    always_comb begin
        err_d = err_q;
        if (cmd_SH_EN && !RSH_LE && (occ_q == '0))
            err_d = 1'b1;
        if (RSH_LE && !cmd_SH_EN && (occ_q != '0))
            err_d = 1'b1;
        if (!CLR && CE_compEN && (cnt_c_q == C_LAT) && flag_c_q)
            err_d = 1'b1;
        if (!CLR && CE_STOPcompEN && (cnt_s_q == S_LAT) && flag_s_q)
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!RST_n)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_constructor_timing_unit.sv
// Randomized and directed bench for constructor_timing_unit against a queue/integer reference model.
module tb_constructor_timing_unit;

    localparam int CNT_W     = 3;
    localparam int COMP_LAT  = 5;
    localparam int STOP_LAT  = 3;
    localparam int CMD_DEPTH = 4;
    localparam int CMD_W     = 2;

    logic                       clk = 1'b0;
    logic                       RST_n = 1'b0;
    logic                       CLR = 1'b0;
    logic                       CE_compEN = 1'b0;
    logic                       CE_STOPcompEN = 1'b0;
    logic                       RSH_LE = 1'b0;
    logic                       cmd_SH_EN = 1'b0;
    logic [CMD_DEPTH*CMD_W-1:0] CMD_IN = '0;
    logic                       CNT_compEN_OUT;
    logic                       CNT_STOPcompEN_OUT;
    logic [CMD_W-1:0]           CMD_OUT;
    logic                       CMD_VALID;
    logic                       CMD_LAST;
    logic                       ERR;

    always #5 clk = ~clk;

    constructor_timing_unit #(
        .CNT_W(CNT_W), .COMP_LAT(COMP_LAT), .STOP_LAT(STOP_LAT),
        .CMD_DEPTH(CMD_DEPTH), .CMD_W(CMD_W)
    ) dut (
        .clk(clk), .RST_n(RST_n), .CLR(CLR),
        .CE_compEN(CE_compEN), .CE_STOPcompEN(CE_STOPcompEN),
        .RSH_LE(RSH_LE), .cmd_SH_EN(cmd_SH_EN), .CMD_IN(CMD_IN),
        .CNT_compEN_OUT(CNT_compEN_OUT), .CNT_STOPcompEN_OUT(CNT_STOPcompEN_OUT),
        .CMD_OUT(CMD_OUT), .CMD_VALID(CMD_VALID), .CMD_LAST(CMD_LAST), .ERR(ERR)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain integers for counts, a queue of pending commands.
    int               m_cnt_c, m_cnt_s;
    bit               m_flag_c, m_flag_s, m_err;
    logic [CMD_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!RST_n) begin
            m_cnt_c = 0; m_cnt_s = 0; m_flag_c = 0; m_flag_s = 0; m_err = 0;
            exp_q.delete();
        end else begin
`ifdef CTU_PROTOCOL_CHECK_EN
            if (cmd_SH_EN && !RSH_LE && exp_q.size() == 0) m_err = 1;
            if (RSH_LE && !cmd_SH_EN && exp_q.size() > 0) m_err = 1;
            if (!CLR && CE_compEN && m_flag_c) m_err = 1;
            if (!CLR && CE_STOPcompEN && m_flag_s) m_err = 1;
`endif
            if (CLR) begin
                m_cnt_c = 0; m_cnt_s = 0;
            end else begin
                if (CE_compEN) m_cnt_c = (m_cnt_c + 1 > COMP_LAT) ? COMP_LAT : m_cnt_c + 1;
                if (CE_STOPcompEN) m_cnt_s = (m_cnt_s + 1 > STOP_LAT) ? STOP_LAT : m_cnt_s + 1;
            end
            m_flag_c = (m_cnt_c == COMP_LAT);
            m_flag_s = (m_cnt_s == STOP_LAT);
            if (RSH_LE) begin
                exp_q.delete();
                for (int i = 0; i < CMD_DEPTH; i++) exp_q.push_back(CMD_IN[i*CMD_W +: CMD_W]);
            end else if (cmd_SH_EN && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic compare_all();
        check("cnt_comp_flag", 32'(CNT_compEN_OUT), 32'(m_flag_c));
        check("cnt_stop_flag", 32'(CNT_STOPcompEN_OUT), 32'(m_flag_s));
        check("cmd_out", 32'(CMD_OUT), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
        check("cmd_valid", 32'(CMD_VALID), 32'(exp_q.size() != 0));
        check("cmd_last", 32'(CMD_LAST), 32'(exp_q.size() == 1));
        check("err", 32'(ERR), 32'(m_err));
    endtask

    task automatic cycle(input logic rst_n, input logic clr, input logic cec, input logic ces,
                         input logic le, input logic sh, input logic [CMD_DEPTH*CMD_W-1:0] cmd_in);
        RST_n = rst_n; CLR = clr; CE_compEN = cec; CE_STOPcompEN = ces;
        RSH_LE = le; cmd_SH_EN = sh; CMD_IN = cmd_in;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        // Reset and counting
        cycle(0, 0, 0, 0, 0, 0, '0);
        cycle(0, 0, 0, 0, 0, 0, '0);
        check("reset_all_zero", 32'({CNT_compEN_OUT, CNT_STOPcompEN_OUT, CMD_OUT, CMD_VALID, CMD_LAST, ERR}), 32'd0);
        for (int k = 1; k <= 15; k++) begin
            cycle(1, 0, 1, 0, 0, 0, '0);
            check("comp_lat_direct", 32'(CNT_compEN_OUT), 32'(k >= COMP_LAT));
        end

        // Clear priority on the stop counter
        cycle(1, 1, 0, 0, 0, 0, '0);
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 1, 0, 0, '0);
        check("stop_flag_set", 32'(CNT_STOPcompEN_OUT), 32'd1);
        cycle(1, 1, 0, 1, 0, 0, '0);
        check("stop_clr_wins", 32'(CNT_STOPcompEN_OUT), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            cycle(1, 0, 0, 1, 0, 0, '0);
            check("stop_relat", 32'(CNT_STOPcompEN_OUT), 32'(k == 3));
        end

        // Load and drain
        cycle(1, 0, 0, 0, 1, 0, 8'b11_10_01_00);
        check("load_head", 32'({CMD_OUT, CMD_VALID, CMD_LAST}), 32'b00_1_0);
        cycle(1, 0, 0, 0, 0, 1, '0);
        check("drain1", 32'({CMD_OUT, CMD_LAST}), 32'b01_0);
        cycle(1, 0, 0, 0, 0, 1, '0);
        check("drain2", 32'({CMD_OUT, CMD_LAST}), 32'b10_0);
        cycle(1, 0, 0, 0, 0, 1, '0);
        check("drain3", 32'({CMD_OUT, CMD_LAST}), 32'b11_1);
        cycle(1, 0, 0, 0, 0, 1, '0);
        check("drained", 32'({CMD_OUT, CMD_VALID}), 32'b00_0);

        // Simultaneous load and shift with two slots left
        cycle(1, 0, 0, 0, 1, 0, 8'h1B);
        cycle(1, 0, 0, 0, 0, 1, '0);
        cycle(1, 0, 0, 0, 0, 1, '0);
        cycle(1, 0, 0, 0, 1, 1, 8'hE4);
        check("load_wins", 32'({CMD_OUT, CMD_VALID, CMD_LAST}), 32'b00_1_0);
        for (int k = 0; k < 4; k++) cycle(1, 0, 0, 0, 0, 1, '0);
        check("occ4_drain", 32'(CMD_VALID), 32'd0);

        // Underflow
        cycle(1, 0, 0, 0, 0, 1, '0);
        cycle(1, 0, 0, 0, 0, 0, '0);
        cycle(1, 0, 0, 0, 0, 0, '0);

        // Reset mid-operation
        cycle(1, 0, 0, 0, 1, 0, 8'h6C);
        cycle(1, 1, 0, 0, 0, 1, '0);
        cycle(1, 0, 1, 0, 0, 0, '0);
        cycle(1, 0, 1, 0, 0, 0, '0);
        cycle(0, 0, 1, 0, 0, 0, '0);
        check("midrst_zero", 32'({CNT_compEN_OUT, CNT_STOPcompEN_OUT, CMD_OUT, CMD_VALID, CMD_LAST, ERR}), 32'd0);
        for (int k = 1; k <= COMP_LAT; k++) begin
            cycle(1, 0, 1, 0, 0, 0, '0);
            check("post_rst_lat", 32'(CNT_compEN_OUT), 32'(k == COMP_LAT));
        end

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) == 0),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 2) == 0), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
